// File: rtl/memory_responder.sv
// memory_responder: word-addressed RAM slave with fixed latency pipeline and in-order response FIFO
module memory_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] m_address,
  input  logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_write,
  input  logic                  m_valid,
  output logic                  m_ready,
  output logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_valid,
  input  logic                  s_ready
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  logic [DATA_WIDTH-1:0] ram [DEPTH];
  logic [DATA_WIDTH-1:0] fq [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] pd [LATENCY];
  logic [LATENCY-1:0]    pv;
  logic [CW-1:0]         wp, rp, used, outstanding, outstanding_n;
  logic [DATA_WIDTH-1:0] last;
  logic [IW-1:0]         idx;
  logic                  accept, pop, push;
  logic                  unused;
  assign idx           = m_address[2 +: IW];
  assign accept        = m_valid && m_ready;
  assign pop           = s_valid && s_ready;
  assign push          = pv[LATENCY-1];
  assign s_valid       = used != '0;
  assign s_data        = s_valid ? fq[rp[PW-1:0]] : last;
  assign outstanding_n = outstanding + CW'(accept) - CW'(pop);
  assign unused        = ^{m_address[1:0], m_address[ADDR_WIDTH-1:IW+2], wp[PW], rp[PW]};
  always_ff @(posedge clock)
    if (accept && m_write) ram[idx] <= m_data;
  // write responses echo the data; reads see the RAM before this edge's write lands
  always_ff @(posedge clock) begin
    pd[0] <= m_write ? m_data : ram[idx];
    for (int i = 1; i < LATENCY; i++) pd[i] <= pd[i-1];
    if (push) fq[wp[PW-1:0]] <= pd[LATENCY-1];
  end
  // outstanding covers pipeline plus FIFO, so gating m_ready on it keeps the FIFO from overflowing
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      pv          <= '0;
      wp          <= '0;
      rp          <= '0;
      used        <= '0;
      outstanding <= '0;
      m_ready     <= 1'b0;
      last        <= '0;
    end else begin
      pv          <= (pv << 1) | LATENCY'(accept);
      wp          <= wp + CW'(push);
      rp          <= rp + CW'(pop);
      used        <= used + CW'(push) - CW'(pop);
      outstanding <= outstanding_n;
      m_ready     <= outstanding_n < CW'(FIFO_DEPTH);
      if (pop) last <= fq[rp[PW-1:0]];
    end
endmodule
